dc_fill_poller: RTL and testbench

- Shares one polling engine across NUM_FIFO dual-clock FIFO CSR slaves.
- Reads each FIFO's fill level round-robin and produces a per-FIFO almost_full flag with hysteresis.
- Sits in the FIFO-facing clock domain in front of the DC FIFOs that feed the pipeline.
- Replaces free-running, always-read level checks with a sequenced, latency-aware read controller.

---
 rtl/dc_fill_poller.sv | 126 ++++++++++++
 tb/tb_dc_fill_poller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dc_fill_poller.sv
// rtl/dc_fill_poller.sv - round-robin fill-level poller with hysteretic almost_full flags
module dc_fill_poller #(
  parameter int NUM_FIFO     = 4,
  parameter int READ_LATENCY = 1,
  parameter int FULL_LEVEL   = 490,
  parameter int RESUME_LEVEL = 400,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic [NUM_FIFO-1:0]      csr_address,
  output logic [NUM_FIFO-1:0]      csr_read,
  output logic [NUM_FIFO-1:0]      csr_write,
  output logic [32*NUM_FIFO-1:0]   csr_writedata,
  input  logic [32*NUM_FIFO-1:0]   csr_readdata,
  output logic [NUM_FIFO-1:0]      almost_full,
  output logic                     any_almost_full,
  output logic [NUM_FIFO-1:0]      level_err,
  output logic                     sweep_done
);

  localparam int IDX_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_FIFO - 1);
  localparam logic [LAT_W-1:0] C_LAT      = LAT_W'(READ_LATENCY);
  localparam logic [31:0]      C_DEPTH    = 32'(FIFO_DEPTH);
  localparam logic [31:0]      C_FULL     = 32'(FULL_LEVEL);
  localparam logic [31:0]      C_RESUME   = 32'(RESUME_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [LAT_W-1:0]    r_lat_cnt;
  logic [NUM_FIFO-1:0] r_csr_read;
  logic [NUM_FIFO-1:0] r_almost_full;
  logic                r_any_almost_full;
  logic [NUM_FIFO-1:0] r_level_err;
  logic                r_sweep_done;

  logic [31:0]         w_level;
  logic                w_sample;
  logic [IDX_W-1:0]    w_idx_next;
  logic [NUM_FIFO-1:0] w_sel_cur;
  logic [NUM_FIFO-1:0] w_sel_next;

  // Sample point, next poll target and one-hot strobes for the current and next FIFO
  always_comb begin
    w_level    = csr_readdata[32*r_idx +: 32];
    w_sample   = (r_state == S_WAIT) && (r_lat_cnt == C_LAT);
    w_idx_next = (r_idx == C_LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    w_sel_cur  = NUM_FIFO'(1) << r_idx;
    w_sel_next = NUM_FIFO'(1) << w_idx_next;
  end

  // Poll sequencer: issue one read, wait out the latency, evaluate, advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_idx             <= '0;
      r_lat_cnt         <= '0;
      r_csr_read        <= '0;
      r_almost_full     <= '0;
      r_any_almost_full <= 1'b0;
      r_level_err       <= '0;
      r_sweep_done      <= 1'b0;
    end else begin
      r_csr_read        <= '0;
      r_sweep_done      <= 1'b0;
      r_any_almost_full <= |r_almost_full;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state    <= S_REQ;
            r_csr_read <= w_sel_cur;
          end
        end
        S_REQ: begin
          // The read strobe is already on the bus; the read is never abandoned
          r_lat_cnt <= LAT_W'(1);
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          r_lat_cnt <= r_lat_cnt + LAT_W'(1);
          if (w_sample) begin
            if (w_level > C_DEPTH) begin
              r_level_err[r_idx]   <= 1'b1;
              r_almost_full[r_idx] <= 1'b1;
            end else if (w_level >= C_FULL) begin
              r_almost_full[r_idx] <= 1'b1;
            end else if (w_level <= C_RESUME) begin
              r_almost_full[r_idx] <= 1'b0;
            end
            r_idx        <= w_idx_next;
            r_sweep_done <= (r_idx == C_LAST_IDX);
            if (enable) begin
              r_state    <= S_REQ;
              r_csr_read <= w_sel_next;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign csr_address     = '0;
  assign csr_write       = '0;
  assign csr_writedata   = '0;
  assign csr_read        = r_csr_read;
  assign almost_full     = r_almost_full;
  assign any_almost_full = r_any_almost_full;
  assign level_err       = r_level_err;
  assign sweep_done      = r_sweep_done;

endmodule

// File: tb/tb_dc_fill_poller.sv
// tb/tb_dc_fill_poller.sv - self-checking bench for dc_fill_poller
module tb_dc_fill_poller;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [127:0] rd;
  logic [3:0]   addr, rs, wr, af, err;
  logic [127:0] wd;
  logic         any_af, sd;

  logic         en3;
  logic [63:0]  rd3;
  logic [1:0]   addr3, rs3, wr3, af3, err3;
  logic [63:0]  wd3;
  logic         any3, sd3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   f;
    logic [31:0] lvl;
    logic af;
    logic err;
  } vec_t;

  typedef struct {
    int   f;
    logic af;
    logic err;
    int   due;
  } sb_t;

  sb_t sbq[$];

  dc_fill_poller #(.NUM_FIFO(4), .READ_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(en),
    .csr_address(addr), .csr_read(rs), .csr_write(wr), .csr_writedata(wd),
    .csr_readdata(rd), .almost_full(af), .any_almost_full(any_af),
    .level_err(err), .sweep_done(sd)
  );

  dc_fill_poller #(.NUM_FIFO(2), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(en3),
    .csr_address(addr3), .csr_read(rs3), .csr_write(wr3), .csr_writedata(wd3),
    .csr_readdata(rd3), .almost_full(af3), .any_almost_full(any3),
    .level_err(err3), .sweep_done(sd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: flag results due RL+1 cycles after the observed read strobe
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_t e;
      e = sbq.pop_front();
      chk($sformatf("sb_af[%0d]", e.f), {127'd0, af[e.f]}, {127'd0, e.af});
      chk($sformatf("sb_err[%0d]", e.f), {127'd0, err[e.f]}, {127'd0, e.err});
    end
  end

  task automatic wait_req(input int f, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (rs[f]) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_req[%0d]: got no read strobe expected one within 64 cycles", f);
    end
  endtask

  vec_t vecs[15];
  logic [3:0] pat[10];

  initial begin
    bit ok;
    sb_t e;

    vecs[0]  = '{1, 32'd489, 1'b0, 1'b0};
    vecs[1]  = '{1, 32'd490, 1'b1, 1'b0};
    vecs[2]  = '{1, 32'd450, 1'b1, 1'b0};
    vecs[3]  = '{1, 32'd400, 1'b0, 1'b0};
    vecs[4]  = '{1, 32'd401, 1'b0, 1'b0};
    vecs[5]  = '{2, 32'd600, 1'b1, 1'b1};
    vecs[6]  = '{2, 32'd10,  1'b0, 1'b1};
    vecs[7]  = '{0, 32'd512, 1'b1, 1'b0};
    vecs[8]  = '{0, 32'd513, 1'b1, 1'b1};
    vecs[9]  = '{0, 32'd0,   1'b0, 1'b1};
    vecs[10] = '{3, 32'd491, 1'b1, 1'b0};
    vecs[11] = '{3, 32'd399, 1'b0, 1'b0};
    vecs[12] = '{3, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[13] = '{3, 32'd399, 1'b0, 1'b1};
    vecs[14] = '{1, 32'd495, 1'b1, 1'b0};

    pat[0] = 4'b0001; pat[1] = 4'b0000; pat[2] = 4'b0010; pat[3] = 4'b0000;
    pat[4] = 4'b0100; pat[5] = 4'b0000; pat[6] = 4'b1000; pat[7] = 4'b0000;
    pat[8] = 4'b0001; pat[9] = 4'b0000;

    rst_n = 1'b0; en = 1'b0; en3 = 1'b0; rd = '0; rd3 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_csr_read", rs, 0);
    chk("rst_af", af, 0);
    chk("rst_any", any_af, 0);
    chk("rst_err", err, 0);
    chk("rst_sweep", sd, 0);
    chk("rst_const", {addr, wr, wd[63:0]}, 0);
    chk("rst_dut3", {rs3, af3, err3, any3, sd3}, 0);

    // Round-robin strobe pattern and sweep_done timing
    rst_n = 1'b1; en = 1'b1;
    wait_req(0, ok);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("pat_read[%0d]", k), rs, pat[k]);
      chk($sformatf("pat_sweep[%0d]", k), sd, (k == 8) ? 1 : 0);
      @(negedge clk);
    end

    // Table-driven level vectors through the scoreboard
    for (int i = 0; i < 15; i++) begin
      rd[32*vecs[i].f +: 32] = vecs[i].lvl;
      wait_req(vecs[i].f, ok);
      if (ok) begin
        e.f = vecs[i].f; e.af = vecs[i].af; e.err = vecs[i].err; e.due = cyc + 2;
        sbq.push_back(e);
      end
      repeat (2) @(negedge clk);
    end
    rd[63:32] = 32'd0;
    repeat (10) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("err_sticky", err, 4'b1101);
    chk("af_after_table", af, 0);

    // Enable dropped in the REQ cycle of FIFO3
    wait_req(0, ok);
    rd[127:96] = 32'd495;
    wait_req(3, ok);
    en = 1'b0;
    chk("drop_af_t0", af[3], 0);
    @(negedge clk);
    chk("drop_read_t1", rs, 0);
    @(negedge clk);
    chk("drop_af_t2", af[3], 1);
    chk("drop_any_t2", any_af, 0);
    chk("drop_sweep_t2", sd, 1);
    @(negedge clk);
    chk("drop_any_t3", any_af, 1);
    chk("drop_sweep_t3", sd, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("idle_read[%0d]", k), rs, 0);
    end
    chk("idle_retain", af, 4'b1000);
    rd[127:96] = 32'd0;
    en = 1'b1;
    @(negedge clk);
    chk("resume_fifo0", rs, 4'b0001);

    // Async reset mid-WAIT with a pending full reading
    rd[31:0] = 32'd500;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_af", af, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_read", rs, 0);
    chk("mid_rst_any", any_af, 0);
    @(negedge clk);
    rd[31:0] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_fifo0", rs, 4'b0001);
    repeat (4) @(negedge clk);
    chk("post_rst_af", af, 0);

    // READ_LATENCY=3: only the t+3 value counts, REQ spacing is 4 cycles
    en3 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(negedge clk);
      if (rs3[0]) ok = 1'b1;
    end
    chk("rl3_first_req", ok, 1);
    @(negedge clk); rd3[31:0] = 32'd600; chk("rl3_gap1", rs3, 0);
    @(negedge clk); rd3[31:0] = 32'd600; chk("rl3_gap2", rs3, 0);
    @(negedge clk); rd3[31:0] = 32'd300; chk("rl3_gap3", rs3, 0);
    @(negedge clk); rd3[31:0] = 32'd600;
    chk("rl3_af_a", af3[0], 0);
    chk("rl3_err_a", err3[0], 0);
    chk("rl3_req_fifo1", rs3, 2'b10);
    repeat (3) @(negedge clk);
    chk("rl3_gap_b", rs3, 0);
    @(negedge clk);
    chk("rl3_req_fifo0", rs3, 2'b01);
    @(negedge clk); rd3[31:0] = 32'd0;
    @(negedge clk); rd3[31:0] = 32'd0;
    @(negedge clk); rd3[31:0] = 32'd495;
    @(negedge clk);
    chk("rl3_af_b", af3[0], 1);
    chk("rl3_err_b", err3, 0);
    en3 = 1'b0;
    rd3 = '0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
